nrzi_tx_controller: RTL and testbench

- Frame-level transmit sequencer for the NRZI serial line.
- Accepts bytes over a valid/ready interface and sends each frame as: SYNC pattern, then data LSB-first with bit stuffing, then EOP.
- NRZI-encodes every bit and drives the line plus its output enable.
- Sits between the byte-oriented packet source and the line driver; one bit time equals one clk cycle.

---
 rtl/nrzi_tx_controller.sv | 240 ++++++++++++++++++++++++
 tb/tb_nrzi_tx_controller.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nrzi_tx_controller.sv
// -----------------------------------------------------------------------------
// nrzi_tx_controller
//
// Frame-level transmit sequencer for an NRZI serial line. Bytes arrive over a
// valid/ready interface and each frame goes out as an 8-bit SYNC pattern, the
// data bytes LSB-first with bit stuffing, and a 3-cycle EOP. Every SYNC/DATA/
// STUFF bit is NRZI-encoded: a raw 0 toggles the line, a raw 1 holds it. One
// bit time equals one clk cycle.
//
// Ports:
//   clk        rising-edge clock, one bit time per cycle
//   rst        synchronous active-low reset
//   tx_data    byte to send
//   tx_valid   tx_data / tx_last are valid
//   tx_last    tx_data is the final byte of the frame
//   tx_ready   controller accepts a byte on this cycle's edge
//   line_out   NRZI line level (registered)
//   line_oe    line driver enable (registered)
//   busy       frame in progress
//   frame_done one-cycle pulse, frame completed normally
//   frame_err  one-cycle pulse, frame aborted on underrun
// -----------------------------------------------------------------------------
module nrzi_tx_controller #(
    parameter logic [7:0]  SYNC_PATTERN = 8'h80,
    parameter int unsigned STUFF_LEN    = 6,
    parameter logic        IDLE_LEVEL   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       line_out,
    output logic       line_oe,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_err
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        STUFF,
        EOP
    } state_t;

    localparam logic [2:0] STUFF_CNT = 3'(STUFF_LEN);

    // The state register names the slot currently on the line. The combinational
    // block works one slot ahead: it picks the next slot and its raw bit so that
    // line_out can be registered and still change on the same edge as the state.
    state_t     state, state_nxt;
    logic [2:0] bit_idx, bit_idx_nxt;     // index of the data/sync bit on the line
    logic [2:0] ones_cnt, ones_nxt;       // consecutive raw 1s, including the current bit
    logic [1:0] eop_cnt, eop_cnt_nxt;
    logic       underrun, underrun_nxt;   // current frame ends with frame_err
    logic [7:0] hold_reg;
    logic       hold_full;
    logic       hold_last;
    logic [7:0] shift_reg;
    logic       shift_last;
    logic       last_accepted;            // tx_last byte taken, no more transfers this frame

    logic       accept;
    logic       load_shift;
    logic       at_boundary;
    logic       done_nxt, err_nxt;
    logic [7:0] next_byte;
    logic       raw_nxt;
    logic       line_out_nxt;

    assign busy   = (state != IDLE);
    assign accept = tx_valid & tx_ready;

    always_comb begin
        tx_ready = 1'b0;
        if (rst) begin
            unique case (state)
                IDLE:              tx_ready = 1'b1;
                SYNC, DATA, STUFF: tx_ready = !hold_full && !last_accepted;
                default:           tx_ready = 1'b0;
            endcase
        end
    end

    // Next-slot selection.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_nxt    = state;
        bit_idx_nxt  = bit_idx;
        eop_cnt_nxt  = eop_cnt;
        underrun_nxt = underrun;
        load_shift   = 1'b0;
        at_boundary  = 1'b0;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt    = SYNC;
                    bit_idx_nxt  = 3'd0;
                    underrun_nxt = 1'b0;
                end
            end
            SYNC: begin
                if (bit_idx == 3'd7) begin
                    state_nxt   = DATA;
                    bit_idx_nxt = 3'd0;
                    load_shift  = 1'b1;
                end else begin
                    bit_idx_nxt = bit_idx + 3'd1;
                end
            end
            DATA: begin
                // A stuff bit takes priority over the byte boundary, so a run of
                // ones ending a byte (or the frame) is still broken up.
                if (ones_cnt == STUFF_CNT) begin
                    state_nxt = STUFF;
                end else if (bit_idx == 3'd7) begin
                    at_boundary = 1'b1;
                end else begin
                    bit_idx_nxt = bit_idx + 3'd1;
                end
            end
            STUFF: begin
                // bit_idx still points at the data bit sent before the stuff bit.
                if (bit_idx == 3'd7) begin
                    at_boundary = 1'b1;
                end else begin
                    state_nxt   = DATA;
                    bit_idx_nxt = bit_idx + 3'd1;
                end
            end
            EOP: begin
                if (eop_cnt == 2'd2) begin
                    state_nxt = IDLE;
                    done_nxt  = !underrun;
                    err_nxt   = underrun;
                end else begin
                    eop_cnt_nxt = eop_cnt + 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (at_boundary) begin
            bit_idx_nxt = 3'd0;
            if (shift_last) begin
                state_nxt   = EOP;
                eop_cnt_nxt = 2'd0;
            end else if (hold_full) begin
                state_nxt  = DATA;
                load_shift = 1'b1;
            end else begin
                state_nxt    = EOP;
                eop_cnt_nxt  = 2'd0;
                underrun_nxt = 1'b1;
            end
        end

        // Raw bit and line level for the slot being entered.
        next_byte = load_shift ? hold_reg : shift_reg;
        unique case (state_nxt)
            SYNC:    raw_nxt = SYNC_PATTERN[bit_idx_nxt];
            DATA:    raw_nxt = next_byte[bit_idx_nxt];
            STUFF:   raw_nxt = 1'b0;
            default: raw_nxt = 1'b1;
        endcase

        ones_nxt     = 3'd0;
        line_out_nxt = IDLE_LEVEL;
        unique case (state_nxt)
            SYNC, DATA, STUFF: begin
                line_out_nxt = raw_nxt ? line_out : ~line_out;
                ones_nxt     = raw_nxt ? ones_cnt + 3'd1 : 3'd0;
            end
            EOP:     line_out_nxt = (eop_cnt_nxt == 2'd2) ? IDLE_LEVEL : 1'b0;
            default: line_out_nxt = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the byte registers are cleared as well, so a frame started
            // after a mid-frame reset sees no stale holding byte or flags.
            state         <= IDLE;
            bit_idx       <= 3'd0;
            ones_cnt      <= 3'd0;
            eop_cnt       <= 2'd0;
            underrun      <= 1'b0;
            hold_reg      <= 8'h00;
            hold_full     <= 1'b0;
            hold_last     <= 1'b0;
            shift_reg     <= 8'h00;
            shift_last    <= 1'b0;
            last_accepted <= 1'b0;
            line_out      <= IDLE_LEVEL;
            line_oe       <= 1'b0;
            frame_done    <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // updates from the same pre-edge values.
            state      <= state_nxt;
            bit_idx    <= bit_idx_nxt;
            ones_cnt   <= ones_nxt;
            eop_cnt    <= eop_cnt_nxt;
            underrun   <= underrun_nxt;
            line_out   <= line_out_nxt;
            line_oe    <= (state_nxt != IDLE);
            frame_done <= done_nxt;
            frame_err  <= err_nxt;

            // accept and load_shift never coincide: tx_ready is low while full.
            if (accept) begin
                hold_reg  <= tx_data;
                hold_full <= 1'b1;
                hold_last <= tx_last;
            end else if (load_shift) begin
                hold_full <= 1'b0;
            end

            if (load_shift) begin
                shift_reg  <= next_byte;
                shift_last <= hold_last;
            end

            if (state == EOP && state_nxt == IDLE) begin
                last_accepted <= 1'b0;
            end else if (accept && tx_last) begin
                last_accepted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nrzi_tx_controller.sv
// -----------------------------------------------------------------------------
// tb_nrzi_tx_controller
//
// Self-checking bench for nrzi_tx_controller. Expected line waveforms come from
// a frame-level model: build the raw bit list (sync, data LSB-first with a 0
// after every six consecutive 1s), NRZI-encode it from the idle level, append
// the EOP levels. A negedge monitor records line_out on every enabled cycle and
// counts frame_done / frame_err pulses.
// -----------------------------------------------------------------------------
module tb_nrzi_tx_controller;

    localparam logic [7:0] SYNC_BYTE = 8'h80;
    localparam int         RUN_LEN   = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready;
    logic       line_out;
    logic       line_oe;
    logic       busy;
    logic       frame_done;
    logic       frame_err;

    nrzi_tx_controller dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_last    (tx_last),
        .tx_ready   (tx_ready),
        .line_out   (line_out),
        .line_oe    (line_oe),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int   tests_run    = 0;
    int   tests_failed = 0;

    logic cap_q[$];
    int   done_cnt = 0;
    int   err_cnt  = 0;
    logic exp_q[$];

    logic ready_done;
    logic ready_oe;
    logic post_oe;

    always @(negedge clk) begin
        if (line_oe) cap_q.push_back(line_out);
        if (frame_done) done_cnt <= done_cnt + 1;
        if (frame_err) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer bytes back to back, each as soon as tx_ready allows.
    task automatic send_bytes(input logic [7:0] b[$], input bit mark_last);
        for (int i = 0; i < b.size(); i++) begin
            int waited = 0;
            @(negedge clk);
            tx_valid = 1'b1;
            tx_data  = b[i];
            tx_last  = mark_last && (i == b.size() - 1);
            while (!tx_ready && waited < 100) begin
                @(negedge clk);
                waited++;
            end
            check($sformatf("ready_wait_b%0d", i), 32'(waited < 100), 32'd1);
            if (i == 0) begin
                ready_done = frame_done;
                ready_oe   = line_oe;
            end
            @(posedge clk);
        end
        @(negedge clk);
        post_oe  = line_oe;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    // Wait for the end-of-frame pulse; count cycles with tx_ready high while busy.
    task automatic wait_end(output int ready_hi);
        int i;
        ready_hi = 0;
        for (i = 0; i < 200; i++) begin
            if (frame_done || frame_err) break;
            if (busy && tx_ready) ready_hi++;
            @(negedge clk);
        end
        check("frame_end_seen", 32'(i < 200), 32'd1);
        repeat (2) @(negedge clk);
        @(posedge clk);
    endtask

    // Frame-level reference: appends the expected enabled-cycle line levels.
    task automatic build_expected(input logic [7:0] b[$]);
        logic       raw[$];
        logic [7:0] sp;
        logic [7:0] cur;
        int         ones;
        logic       lvl;
        sp   = SYNC_BYTE;
        ones = 0;
        for (int k = 0; k < 8; k++) begin
            raw.push_back(sp[k]);
            ones = sp[k] ? ones + 1 : 0;
        end
        foreach (b[j]) begin
            cur = b[j];
            for (int k = 0; k < 8; k++) begin
                raw.push_back(cur[k]);
                ones = cur[k] ? ones + 1 : 0;
                if (ones == RUN_LEN) begin
                    raw.push_back(1'b0);
                    ones = 0;
                end
            end
        end
        lvl = 1'b1;
        foreach (raw[k]) begin
            if (!raw[k]) lvl = !lvl;
            exp_q.push_back(lvl);
        end
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
    endtask

    task automatic check_frame(input string tag, input int cb, input int db, input int eb,
                               input int exp_done, input int exp_err);
        int n;
        n = cap_q.size() - cb;
        check({tag, "_len"}, 32'(n), 32'(exp_q.size()));
        for (int k = 0; k < n && k < exp_q.size(); k++)
            check($sformatf("%s_bit%0d", tag, k), 32'(cap_q[cb + k]), 32'(exp_q[k]));
        check({tag, "_done"}, 32'(done_cnt - db), 32'(exp_done));
        check({tag, "_err"}, 32'(err_cnt - eb), 32'(exp_err));
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] q[$];
        logic [8:0] got;
        int         cb, db, eb, rh, nb;
        bit         under;

        // Reset state, observed while rst is still low.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_oe", 32'(line_oe), 32'd0);
        check("rst_line", 32'(line_out), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(tx_ready), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(tx_ready), 32'd1);
        check("idle_oe", 32'(line_oe), 32'd0);
        @(posedge clk);

        // Single zero byte: 19 enabled cycles, no stuffing.
        cb = cap_q.size(); db = done_cnt; eb = err_cnt;
        q.delete(); q.push_back(8'h00);
        send_bytes(q, 1'b1);
        wait_end(rh);
        check("t1_len19", 32'(cap_q.size() - cb), 32'd19);
        check("t1_ready_busy", 32'(rh), 32'd0);
        build_expected(q);
        check_frame("t1", cb, db, eb, 1, 0);

        // 0xFF: sync trailing 1 counts, stuff after 5 data bits.
        cb = cap_q.size(); db = done_cnt; eb = err_cnt;
        q.delete(); q.push_back(8'hFF);
        send_bytes(q, 1'b1);
        wait_end(rh);
        check("t2_len20", 32'(cap_q.size() - cb), 32'd20);
        got = '0;
        for (int k = 0; k < 9; k++)
            if (cb + 8 + k < cap_q.size()) got[k] = cap_q[cb + 8 + k];
        check("t2_data_levels", 32'(got), 32'(9'b1_1110_0000));
        build_expected(q);
        check_frame("t2", cb, db, eb, 1, 0);

        // Two-byte frame, continuous data, tx_ready low after the last transfer.
        cb = cap_q.size(); db = done_cnt; eb = err_cnt;
        q.delete(); q.push_back(8'hA5); q.push_back(8'h3C);
        send_bytes(q, 1'b1);
        wait_end(rh);
        check("t3_len27", 32'(cap_q.size() - cb), 32'd27);
        check("t3_ready_after_last", 32'(rh), 32'd0);
        build_expected(q);
        check_frame("t3", cb, db, eb, 1, 0);

        // Underrun: single byte without tx_last.
        cb = cap_q.size(); db = done_cnt; eb = err_cnt;
        q.delete(); q.push_back(8'h01);
        send_bytes(q, 1'b0);
        wait_end(rh);
        build_expected(q);
        check_frame("t4_underrun", cb, db, eb, 0, 1);

        // Reset during the 3rd data bit.
        cb = cap_q.size(); db = done_cnt; eb = err_cnt;
        q.delete(); q.push_back(8'hFF);
        send_bytes(q, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t5_oe", 32'(line_oe), 32'd0);
        check("t5_line", 32'(line_out), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(frame_done), 32'd0);
        check("t5_err", 32'(frame_err), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        @(posedge clk);
        check("t5_no_done", 32'(done_cnt - db), 32'd0);
        check("t5_no_err", 32'(err_cnt - eb), 32'd0);
        cb = cap_q.size(); db = done_cnt; eb = err_cnt;
        send_bytes(q, 1'b1);
        wait_end(rh);
        build_expected(q);
        check_frame("t5_restart", cb, db, eb, 1, 0);

        // Back-to-back frames: second byte offered while the first frame runs.
        cb = cap_q.size(); db = done_cnt; eb = err_cnt;
        q.delete(); q.push_back(8'h00);
        send_bytes(q, 1'b1);
        q.delete(); q.push_back(8'h5A);
        send_bytes(q, 1'b1);
        check("t6_accept_in_done", 32'(ready_done), 32'd1);
        check("t6_accept_oe", 32'(ready_oe), 32'd0);
        check("t6_sync_next", 32'(post_oe), 32'd1);
        wait_end(rh);
        q.delete(); q.push_back(8'h00);
        build_expected(q);
        q.delete(); q.push_back(8'h5A);
        build_expected(q);
        check_frame("t6", cb, db, eb, 2, 0);

        // Randomized frames, some ending in underrun.
        for (int f = 0; f < 20; f++) begin
            nb    = $urandom_range(1, 3);
            under = ($urandom_range(0, 3) == 0);
            q.delete();
            for (int k = 0; k < nb; k++) q.push_back(8'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            cb = cap_q.size(); db = done_cnt; eb = err_cnt;
            send_bytes(q, !under);
            wait_end(rh);
            if (!under) check($sformatf("r%0d_ready_after_last", f), 32'(rh), 32'd0);
            build_expected(q);
            check_frame($sformatf("r%0d", f), cb, db, eb, under ? 0 : 1, under ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
